// File: rtl/nf2_dma_tx_demux.sv
// DMA TX demultiplexer: routes TX FIFO packets to per-queue CPU write ports and forwards RX requests.
// Optional protocol error counter enabled by defining NF2_DMA_TX_ERR_CNT_EN.
module nf2_dma_tx_demux #(
  parameter int DMA_DATA_WIDTH = 32,
  parameter int NUM_CPU_QUEUES = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_reset_n,
  input  logic                        sys_txfifo_empty,
  input  logic [DMA_DATA_WIDTH+3:0]   sys_txfifo_rd_data,
  output logic                        sys_txfifo_rd_inc,
  output logic [NUM_CPU_QUEUES-1:0]   cpu_q_wr,
  output logic [DMA_DATA_WIDTH-1:0]   cpu_q_data,
  output logic                        cpu_q_eop,
  output logic [1:0]                  cpu_q_bytecnt,
  input  logic [NUM_CPU_QUEUES-1:0]   cpu_q_full,
  output logic                        dma_rx_req,
  output logic [3:0]                  dma_rx_req_q,
  input  logic                        dma_rx_req_ack,
  output logic                        proto_err,
  output logic [15:0]                 err_cnt
);

  localparam int W  = DMA_DATA_WIDTH;
  localparam int QW = (NUM_CPU_QUEUES > 1) ? $clog2(NUM_CPU_QUEUES) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DROP, RXREQ} state_t;

  state_t state_reg, state_next;

  logic          present;
  logic          word_is_req;
  logic          word_eop_dir;
  logic [1:0]    word_bytecnt;
  logic [3:0]    word_qid;
  logic [W-1:0]  word_data;
  logic          word_q_ok;
  logic          target_full;

  logic [QW-1:0]             q_reg;
  logic [NUM_CPU_QUEUES-1:0] q_sel;

  logic pop;
  logic wr_en;
  logic err_next;
  logic rx_set;
  logic rx_clr;
  logic q_load;

  logic [NUM_CPU_QUEUES-1:0] cpu_q_wr_reg;
  logic [W-1:0]              cpu_q_data_reg;
  logic                      cpu_q_eop_reg;
  logic [1:0]                cpu_q_bytecnt_reg;
  logic                      dma_rx_req_reg;
  logic [3:0]                dma_rx_req_q_reg;
  logic                      proto_err_reg;

  assign present      = ~sys_txfifo_empty;
  assign word_is_req  = sys_txfifo_rd_data[W+3];
  assign word_eop_dir = sys_txfifo_rd_data[W+2];
  assign word_bytecnt = sys_txfifo_rd_data[W+1:W];
  assign word_qid     = sys_txfifo_rd_data[3:0];
  assign word_data    = sys_txfifo_rd_data[W-1:0];
  assign word_q_ok    = ({28'd0, word_qid} < NUM_CPU_QUEUES);
  assign target_full  = cpu_q_full[q_reg];

  // One-hot decode of the latched target queue
  for (genvar gi = 0; gi < NUM_CPU_QUEUES; gi++) begin : g_qsel
    assign q_sel[gi] = (q_reg == QW'(gi));
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (present && word_is_req) begin
          if (word_q_ok) state_next = word_eop_dir ? RXREQ : XFER;
          else           state_next = word_eop_dir ? IDLE : DROP;
        end
      end
      XFER: begin
        if (present) begin
          if (word_is_req)                      state_next = IDLE;
          else if (!target_full && word_eop_dir) state_next = IDLE;
        end
      end
      DROP: begin
        if (present && (word_is_req || word_eop_dir)) state_next = IDLE;
      end
      RXREQ: begin
        if (dma_rx_req_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    wr_en    = 1'b0;
    err_next = 1'b0;
    rx_set   = 1'b0;
    rx_clr   = 1'b0;
    q_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (present) begin
          pop = 1'b1;
          if (word_is_req && word_q_ok) begin
            rx_set = word_eop_dir;
            q_load = ~word_eop_dir;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      XFER: begin
        // A request here truncates the packet; leave it in the FIFO for IDLE
        if (present) begin
          if (word_is_req) begin
            err_next = 1'b1;
          end else if (!target_full) begin
            pop   = 1'b1;
            wr_en = 1'b1;
          end
        end
      end
      DROP: begin
        pop = present & ~word_is_req;
      end
      RXREQ: begin
        rx_clr = dma_rx_req_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      q_reg             <= '0;
      cpu_q_wr_reg      <= '0;
      cpu_q_data_reg    <= '0;
      cpu_q_eop_reg     <= 1'b0;
      cpu_q_bytecnt_reg <= 2'b00;
      dma_rx_req_reg    <= 1'b0;
      dma_rx_req_q_reg  <= 4'd0;
      proto_err_reg     <= 1'b0;
    end else begin
      if (q_load) q_reg <= word_qid[QW-1:0];
      cpu_q_wr_reg  <= wr_en ? q_sel : '0;
      proto_err_reg <= err_next;
      if (wr_en) begin
        cpu_q_data_reg    <= word_data;
        cpu_q_eop_reg     <= word_eop_dir;
        cpu_q_bytecnt_reg <= word_bytecnt;
      end
      if (rx_set) begin
        dma_rx_req_reg   <= 1'b1;
        dma_rx_req_q_reg <= word_qid;
      end else if (rx_clr) begin
        dma_rx_req_reg   <= 1'b0;
      end
    end
  end

`ifdef NF2_DMA_TX_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      err_cnt_reg <= 16'd0;
    end else if (err_next && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 16'h0000;
`endif

  assign sys_txfifo_rd_inc = pop;
  assign cpu_q_wr          = cpu_q_wr_reg;
  assign cpu_q_data        = cpu_q_data_reg;
  assign cpu_q_eop         = cpu_q_eop_reg;
  assign cpu_q_bytecnt     = cpu_q_bytecnt_reg;
  assign dma_rx_req        = dma_rx_req_reg;
  assign dma_rx_req_q      = dma_rx_req_q_reg;
  assign proto_err         = proto_err_reg;

endmodule

// File: tb/tb_nf2_dma_tx_demux.sv
// Scoreboard bench for nf2_dma_tx_demux: a packet-level parser of the FIFO stream predicts
// the ordered queue writes, RX requests and protocol error count.
module tb_nf2_dma_tx_demux;

  localparam int W  = 32;
  localparam int NQ = 4;

  logic          sys_clk = 1'b0;
  logic          sys_reset_n = 1'b0;
  logic          sys_txfifo_empty = 1'b1;
  logic [W+3:0]  sys_txfifo_rd_data = '0;
  logic          sys_txfifo_rd_inc;
  logic [NQ-1:0] cpu_q_wr;
  logic [W-1:0]  cpu_q_data;
  logic          cpu_q_eop;
  logic [1:0]    cpu_q_bytecnt;
  logic [NQ-1:0] cpu_q_full = '0;
  logic          dma_rx_req;
  logic [3:0]    dma_rx_req_q;
  logic          dma_rx_req_ack = 1'b0;
  logic          proto_err;
  logic [15:0]   err_cnt;

  nf2_dma_tx_demux #(.DMA_DATA_WIDTH(W), .NUM_CPU_QUEUES(NQ)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .sys_txfifo_empty(sys_txfifo_empty), .sys_txfifo_rd_data(sys_txfifo_rd_data),
    .sys_txfifo_rd_inc(sys_txfifo_rd_inc),
    .cpu_q_wr(cpu_q_wr), .cpu_q_data(cpu_q_data), .cpu_q_eop(cpu_q_eop),
    .cpu_q_bytecnt(cpu_q_bytecnt), .cpu_q_full(cpu_q_full),
    .dma_rx_req(dma_rx_req), .dma_rx_req_q(dma_rx_req_q), .dma_rx_req_ack(dma_rx_req_ack),
    .proto_err(proto_err), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit           is_rx;
    logic [3:0]   q;
    logic [W-1:0] data;
    logic         eop;
    logic [1:0]   bc;
  } ev_t;

  ev_t          exp_q[$];
  logic [W+3:0] fifo[$];
  int vectors = 0, miscompares = 0;
  int exp_err = 0, err_seen = 0, wr_seen = 0;
  int gap_pct = 0, full_pct = 0, ack_wait = -1;
  bit pop_pending = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W+3:0] mk_req(input bit dir, input logic [3:0] q);
    logic [W+3:0] w;
    w = {1'b1, dir, 2'($urandom), W'($urandom)};
    w[3:0] = q;
    return w;
  endfunction

  function automatic logic [W+3:0] mk_data(input logic [W-1:0] d, input bit eop, input logic [1:0] bc);
    return {1'b0, eop, bc, d};
  endfunction

  // Packet-level parse of a word stream into expected events and error count
  task automatic run_model(input logic [W+3:0] s[$]);
    int i;
    ev_t e;
    logic [3:0] q;
    bit ok, got_eop;
    i = 0;
    while (i < s.size()) begin
      if (!s[i][W+3]) begin
        exp_err++;
        i++;
      end else begin
        q = s[i][3:0];
        if (s[i][W+2]) begin
          if (q < NQ) begin
            e.is_rx = 1; e.q = q; e.data = '0; e.eop = 0; e.bc = '0;
            exp_q.push_back(e);
          end else begin
            exp_err++;
          end
          i++;
        end else begin
          ok = (q < NQ);
          got_eop = 0;
          if (!ok) exp_err++;
          i++;
          while (i < s.size() && !s[i][W+3] && !got_eop) begin
            if (ok) begin
              e.is_rx = 0; e.q = q; e.data = s[i][W-1:0];
              e.eop = s[i][W+2]; e.bc = s[i][W+1:W];
              exp_q.push_back(e);
            end
            got_eop = s[i][W+2];
            i++;
          end
          if (ok && !got_eop && i < s.size()) exp_err++;
        end
      end
    end
  endtask

  // FIFO / full / ack driver: decisions sampled at negedge, inputs updated 1 after posedge
  initial begin
    forever begin
      @(negedge sys_clk);
      pop_pending = sys_txfifo_rd_inc && !sys_txfifo_empty;
      @(posedge sys_clk);
      #1;
      if (pop_pending && fifo.size() > 0) void'(fifo.pop_front());
      sys_txfifo_empty = (fifo.size() == 0) || ($urandom_range(0, 99) < gap_pct);
      sys_txfifo_rd_data = sys_txfifo_empty ? {$urandom, $urandom} : fifo[0];
      for (int k = 0; k < NQ; k++) cpu_q_full[k] = ($urandom_range(0, 99) < full_pct);
      if (dma_rx_req_ack) begin
        dma_rx_req_ack = 1'b0;
        ack_wait = -1;
      end else if (dma_rx_req) begin
        if (ack_wait < 0) ack_wait = $urandom_range(0, 4);
        if (ack_wait == 0) dma_rx_req_ack = 1'b1;
        else ack_wait--;
      end
    end
  end

  // Monitor: compares every DUT write / RX request against the scoreboard queue
  initial begin
    ev_t e;
    bit prev_req = 0, prev_ack = 0;
    logic [NQ-1:0] prev_full = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_reset_n) begin
        prev_req = 0; prev_ack = 0; prev_full = '0;
        continue;
      end
      if (proto_err) err_seen++;
      if (sys_txfifo_empty) check("pop_on_empty", sys_txfifo_rd_inc, 0);
      if (cpu_q_wr != '0) begin
        wr_seen++;
        check("wr_into_full", cpu_q_wr & prev_full, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_wr", cpu_q_wr, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_kind", e.is_rx, 0);
          check("wr_q", cpu_q_wr, NQ'(1) << e.q);
          check("wr_data", cpu_q_data, e.data);
          check("wr_eop", cpu_q_eop, e.eop);
          check("wr_bytecnt", cpu_q_bytecnt, e.bc);
        end
      end
      if (dma_rx_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rx_req", dma_rx_req, 0);
        end else begin
          e = exp_q.pop_front();
          check("rx_kind", e.is_rx, 1);
          check("rx_q", dma_rx_req_q, e.q);
        end
      end
      if (dma_rx_req) check("pop_during_rxreq", sys_txfifo_rd_inc, 0);
      if (prev_ack) check("rx_req_after_ack", dma_rx_req, 0);
      prev_req  = dma_rx_req;
      prev_ack  = dma_rx_req_ack;
      prev_full = cpu_q_full;
    end
  end

  task automatic check_err_totals();
`ifdef NF2_DMA_TX_ERR_CNT_EN
    check("err_cnt", err_cnt, (exp_err > 65535) ? 65535 : exp_err);
`else
    check("err_cnt", err_cnt, 0);
`endif
    check("proto_err_pulses", err_seen, exp_err);
  endtask

  task automatic run_phase(input string name, input logic [W+3:0] s[$], output int cycles);
    int t;
    logic [W+3:0] full_s[$];
    full_s = s;
    full_s.push_back(mk_req(1, 4'hF));
    run_model(full_s);
    foreach (full_s[k]) fifo.push_back(full_s[k]);
    t = 0;
    while ((fifo.size() > 0 || exp_q.size() > 0 || dma_rx_req) && t < 5000) begin
      @(posedge sys_clk);
      t++;
    end
    if (t >= 5000) check({name, "_timeout"}, 1, 0);
    cycles = t;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    check_err_totals();
    $display("phase %s: %0d cycles, %0d errors expected", name, t, exp_err);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr"}, cpu_q_wr, 0);
    check({tag, "_data"}, cpu_q_data, 0);
    check({tag, "_eop"}, cpu_q_eop, 0);
    check({tag, "_bytecnt"}, cpu_q_bytecnt, 0);
    check({tag, "_rx_req"}, dma_rx_req, 0);
    check({tag, "_rx_req_q"}, dma_rx_req_q, 0);
    check({tag, "_proto_err"}, proto_err, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    logic [W+3:0] s[$];
    int cyc, n, kind, base, t;
    logic [3:0] q;

    repeat (3) @(posedge sys_clk);
    #1;
    check_outputs_zero("reset");
    @(negedge sys_clk);
    sys_reset_n = 1'b1;

    // Back-to-back 3-word packet to queue 2 at full rate
    gap_pct = 0; full_pct = 0;
    s.delete();
    s.push_back(mk_req(0, 4'd2));
    s.push_back(mk_data(32'h11111111, 0, 2'b00));
    s.push_back(mk_data(32'h22222222, 0, 2'b00));
    s.push_back(mk_data(32'hAABBCCDD, 1, 2'b11));
    run_phase("tx_q2", s, cyc);
    check("tx_q2_throughput", (cyc <= 8), 1);

    // Same packet under heavy backpressure
    full_pct = 60;
    run_phase("tx_q2_stall", s, cyc);
    full_pct = 0;

    s.delete();
    s.push_back(mk_req(1, 4'd1));
    run_phase("rx_q1", s, cyc);

    s.delete();
    s.push_back(mk_req(0, 4'd9));
    for (int k = 0; k < 3; k++) s.push_back(mk_data($urandom, (k == 2), 2'($urandom)));
    run_phase("tx_bad_q", s, cyc);

    s.delete();
    s.push_back(mk_req(0, 4'd0));
    s.push_back(mk_data(32'h0000CAFE, 0, 2'b00));
    s.push_back(mk_req(0, 4'd3));
    s.push_back(mk_data(32'h33333333, 0, 2'b00));
    s.push_back(mk_data(32'h44444444, 1, 2'b01));
    run_phase("truncated", s, cyc);

    // Reset mid-packet, then a fresh packet to queue 0
    s.delete();
    s.push_back(mk_req(0, 4'd1));
    for (int k = 0; k < 10; k++) s.push_back(mk_data($urandom, (k == 9), 2'b00));
    run_model(s);
    foreach (s[k]) fifo.push_back(s[k]);
    base = wr_seen;
    t = 0;
    while (wr_seen < base + 2 && t < 1000) begin
      @(posedge sys_clk);
      t++;
    end
    if (t >= 1000) check("mid_reset_timeout", 1, 0);
    @(negedge sys_clk);
    #2;
    sys_reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    fifo.delete();
    exp_q.delete();
    exp_err = 0;
    err_seen = 0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    s.delete();
    s.push_back(mk_req(0, 4'd0));
    for (int k = 0; k < 3; k++) s.push_back(mk_data($urandom, (k == 2), 2'($urandom)));
    run_phase("after_reset", s, cyc);

    // Randomized mixed traffic
    for (int p = 0; p < 10; p++) begin
      gap_pct  = $urandom_range(0, 40);
      full_pct = $urandom_range(0, 50);
      s.delete();
      n = $urandom_range(6, 12);
      for (int j = 0; j < n; j++) begin
        kind = $urandom_range(0, 9);
        if (kind <= 3) begin
          q = 4'($urandom_range(0, NQ - 1));
          s.push_back(mk_req(0, q));
          base = $urandom_range(1, 5);
          for (int k = 0; k < base; k++) s.push_back(mk_data($urandom, (k == base - 1), 2'($urandom)));
        end else if (kind == 4) begin
          s.push_back(mk_req(0, 4'($urandom_range(NQ, 15))));
          base = $urandom_range(0, 3);
          for (int k = 0; k < base; k++) s.push_back(mk_data($urandom, (k == base - 1), 2'($urandom)));
        end else if (kind <= 6) begin
          s.push_back(mk_req(1, 4'($urandom_range(0, NQ - 1))));
        end else if (kind == 7) begin
          s.push_back(mk_req(1, 4'($urandom_range(NQ, 15))));
        end else if (kind == 8) begin
          s.push_back(mk_data($urandom, 1'($urandom), 2'($urandom)));
        end else begin
          s.push_back(mk_req(0, 4'($urandom_range(0, NQ - 1))));
          base = $urandom_range(1, 3);
          for (int k = 0; k < base; k++) s.push_back(mk_data($urandom, 0, 2'($urandom)));
        end
      end
      run_phase($sformatf("random%0d", p), s, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nf2_dma_tx_demux.md
NF2_DMA_TX_DEMUX -- requirements
Module: nf2_dma_tx_demux

Interface
REQ-001 The block SHALL have parameters: DMA_DATA_WIDTH, default 32, data word width; NUM_CPU_QUEUES, default 4, number of CPU queues (max 16).
REQ-002 The block SHALL have these ports (name direction width meaning):
 sys_clk  in  1  system clock; single clock domain.
 sys_reset_n  in  1  reset, asynchronous, active-low.
 sys_txfifo_empty  in  1  TX async FIFO empty; rd_data valid (show-ahead) when low.
 sys_txfifo_rd_data  in  DMA_DATA_WIDTH+4  [35]=type (1 req, 0 data); [34]=EOP (data) or dir (req: 0 tx, 1 rx); [33:32]=bytecnt; [3:0]=queue_id (req).
 sys_txfifo_rd_inc  out  1  pop strobe, same cycle as word consumed.
 cpu_q_wr  out  NUM_CPU_QUEUES  one-hot write strobe to selected CPU queue.
 cpu_q_data  out  DMA_DATA_WIDTH  packet word.
 cpu_q_eop  out  1  last word of packet.
 cpu_q_bytecnt  out  2  00=4 bytes, 01=1, 10=2, 11=3.
 cpu_q_full  in  NUM_CPU_QUEUES  per-queue full; asserted while at most one free slot remains.
 dma_rx_req  out  1  DMA-RX request to CPU-queue read side, held until ack.
 dma_rx_req_q  out  4  queue_id of pending RX request.
 dma_rx_req_ack  in  1  request accepted.
 proto_err  out  1  one-cycle pulse on any protocol error.
 err_cnt  out  16  protocol error count (see Configuration).

Function
REQ-003 The block SHALL implement FSM states IDLE, XFER, DROP, RXREQ.
REQ-004 Word "present" SHALL mean sys_txfifo_empty=0; no pop, write or state change SHALL occur on a non-present word.
REQ-005 In IDLE, a present TX request with queue_id<NUM_CPU_QUEUES SHALL pop, latch queue_id, enter XFER.
REQ-006 In IDLE, a present TX request with queue_id>=NUM_CPU_QUEUES SHALL pop, pulse proto_err, enter DROP.
REQ-007 In IDLE, a present RX request with valid queue_id SHALL pop, register dma_rx_req=1 and dma_rx_req_q=queue_id next cycle, enter RXREQ; invalid queue_id SHALL pop, pulse proto_err, stay IDLE.
REQ-008 In IDLE, a present data word SHALL pop, be discarded, pulse proto_err.
REQ-009 In XFER, a present data word with cpu_q_full[q]=0 SHALL pop; next cycle cpu_q_wr[q]=1 with data, eop, bytecnt registered from that word; pop with EOP=1 SHALL return to IDLE.
REQ-010 In XFER, cpu_q_full[q]=1 SHALL stall (no pop, no write) with no word lost or duplicated.
REQ-011 In XFER, a present request word SHALL NOT be popped; proto_err pulses, state -> IDLE, request reprocessed next cycle; truncated packet gets no EOP write.
REQ-012 In DROP, data words SHALL pop and be discarded; EOP word -> IDLE; request word SHALL NOT pop, -> IDLE.
REQ-013 In RXREQ, no pops SHALL occur; dma_rx_req_ack=1 SHALL clear dma_rx_req next cycle and return to IDLE; ack outside RXREQ SHALL be ignored.
REQ-014 Write latency SHALL be exactly one cycle pop-to-cpu_q_wr; at most one write per cycle; cpu_q_wr otherwise 0.
REQ-015 Sustained throughput SHALL be one word/cycle while FIFO non-empty and target queue not full.

Reset
REQ-016 sys_reset_n=0 SHALL asynchronously force IDLE, all strobes 0, dma_rx_req=0, dma_rx_req_q=0, cpu_q_data/eop/bytecnt=0, err_cnt=0.
REQ-017 Reset mid-packet SHALL abandon the packet without EOP; first non-empty cycle after release is handled in IDLE.

Configuration
REQ-018 With macro NF2_DMA_TX_ERR_CNT_EN defined, err_cnt SHALL increment once per proto_err pulse, saturating at 16'hFFFF.
REQ-019 Without NF2_DMA_TX_ERR_CNT_EN, err_cnt SHALL be constant 0, no counter flops; proto_err unaffected.

Verification
REQ-020 Req tx q=2, data 0x11111111, 0x22222222, 0xAABBCCDD EOP bytecnt=11 -> cpu_q_wr=4'b0100 on three consecutive cycles, last with eop=1, bytecnt=11, then IDLE.
REQ-021 Same packet, cpu_q_full[2]=1 for 5 cycles mid-packet -> no pops during stall; all three words delivered in order, none duplicated.
REQ-022 Req rx q=1, ack after 4 cycles -> dma_rx_req=1, dma_rx_req_q=1 for 4 cycles, 0 cycle after ack; no pops meanwhile.
REQ-023 Req tx q=9 (NUM_CPU_QUEUES=4) + 3 data words ending EOP -> proto_err once, no cpu_q_wr, IDLE; err_cnt=1 with macro, 0 without.
REQ-024 Req tx q=0, one data word, then req tx q=3 -> proto_err; q=3 packet delivered normally on cpu_q_wr[3].
REQ-025 sys_reset_n low mid-packet q=1 -> outputs zero immediately; next req tx q=0 packet delivered correctly.
